mem_arbiter: RTL and testbench

Tag-tracking arbiter between the Icache and Dcache memory ports and the single memory bus. Each cycle it grants the bus to one requester, with Dcache priority and an Icache starvation guard. It records which cache owns each outstanding load tag. Returned data is routed only to the owning cache, so a cache never consumes a transaction it did not issue.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_tag_table.sv | 53 +++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, bus command encoding and owner-table types for the memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned TAG_W        = 4;
  localparam int unsigned NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding load tags: allocate on accepted loads,
// look up and retire on returns, flag orphan returns and reallocation of live tags.
module mem_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_hit_c,
  output logic             ret_owner_c,
  output logic             err_orphan_tag
);

  MEM_TAG_ENTRY owner_tbl [NUM_MEM_TAGS];

  logic ret_active;
  logic orphan_ret;
  logic realloc_violation;

  // Lookup reads the registered entry, so a same-cycle return sees the old owner.
  always_comb begin
    ret_active        = (ret_tag != '0);
    ret_hit_c         = ret_active && owner_tbl[ret_tag].valid;
    ret_owner_c       = owner_tbl[ret_tag].owner;
    orphan_ret        = ret_active && !owner_tbl[ret_tag].valid;
    realloc_violation = alloc_en && owner_tbl[alloc_tag].valid &&
                        !(ret_hit_c && (ret_tag == alloc_tag));
  end

  // Retire on return first, then let a new allocation win the write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_MEM_TAGS); i++) begin
        owner_tbl[i] <= '0;
      end
      err_orphan_tag <= 1'b0;
    end else begin
      if (ret_hit_c) begin
        owner_tbl[ret_tag].valid <= 1'b0;
      end
      if (alloc_en) begin
        owner_tbl[alloc_tag] <= '{valid: 1'b1, owner: MEM_OWNER'(alloc_owner)};
      end
      if (orphan_ret || realloc_violation) begin
        err_orphan_tag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Icache/Dcache to memory-bus arbiter with Dcache priority and tag-based return routing.
// Define MEM_ARB_STARVE_GUARD_EN to enable the Icache starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        Icache2ctrl_command,
  input  logic [XLEN-1:0]   Icache2ctrl_addr,
  input  logic [1:0]        Dcache2ctrl_command,
  input  logic [XLEN-1:0]   Dcache2ctrl_addr,
  input  logic [DATA_W-1:0] Dcache2ctrl_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic [1:0]        proc2mem_command,
  output logic [XLEN-1:0]   proc2mem_addr,
  output logic [DATA_W-1:0] proc2Dmem_data,
  output logic [TAG_W-1:0]  ctrl2Icache_response,
  output logic [TAG_W-1:0]  ctrl2Dcache_response,
  output logic [DATA_W-1:0] ctrl2Icache_data,
  output logic [DATA_W-1:0] ctrl2Dcache_data,
  output logic [TAG_W-1:0]  ctrl2Icache_tag,
  output logic [TAG_W-1:0]  ctrl2Dcache_tag,
  output logic              err_orphan_tag
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic icache_req;
  logic dcache_req;
  logic starve_force;
  logic grant_d;
  logic grant_i;
  logic alloc_en;
  logic ret_hit;
  logic ret_owner;

  assign icache_req = (Icache2ctrl_command != BUS_NONE);
  assign dcache_req = (Dcache2ctrl_command != BUS_NONE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_force = icache_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count cycles the Icache loses to the Dcache; a rejected forced grant holds priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!icache_req) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else if (mem2proc_response != '0) begin
      starve_cnt <= '0;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Grant selection, bus muxing and accept-tag routing.
  always_comb begin
    grant_d              = dcache_req && !starve_force;
    grant_i              = icache_req && !grant_d;
    proc2mem_command     = BUS_NONE;
    proc2mem_addr        = '0;
    proc2Dmem_data       = '0;
    ctrl2Icache_response = '0;
    ctrl2Dcache_response = '0;
    if (grant_d) begin
      proc2mem_command     = Dcache2ctrl_command;
      proc2mem_addr        = Dcache2ctrl_addr;
      proc2Dmem_data       = Dcache2ctrl_data;
      ctrl2Dcache_response = mem2proc_response;
    end else if (grant_i) begin
      proc2mem_command     = Icache2ctrl_command;
      proc2mem_addr        = Icache2ctrl_addr;
      ctrl2Icache_response = mem2proc_response;
    end
    alloc_en = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
  end

  mem_tag_table u_tag_table (
    .clock          (clock),
    .reset          (reset),
    .alloc_en       (alloc_en),
    .alloc_tag      (mem2proc_response),
    .alloc_owner    (grant_d),
    .ret_tag        (mem2proc_tag),
    .ret_hit_c      (ret_hit),
    .ret_owner_c    (ret_owner),
    .err_orphan_tag (err_orphan_tag)
  );

  // Returned data and tag go only to the cache that owns the tag.
  always_comb begin
    ctrl2Icache_data = '0;
    ctrl2Dcache_data = '0;
    ctrl2Icache_tag  = '0;
    ctrl2Dcache_tag  = '0;
    if (ret_hit) begin
      if (ret_owner == OWNER_DCACHE) begin
        ctrl2Dcache_data = mem2proc_data;
        ctrl2Dcache_tag  = mem2proc_tag;
      end else begin
        ctrl2Icache_data = mem2proc_data;
        ctrl2Icache_tag  = mem2proc_tag;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow MEM_ARB_STARVE_GUARD_EN when defined.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic [1:0]        i_cmd;
  logic [XLEN-1:0]   i_addr;
  logic [1:0]        d_cmd;
  logic [XLEN-1:0]   d_addr;
  logic [DATA_W-1:0] d_data;
  logic [TAG_W-1:0]  m_resp;
  logic [DATA_W-1:0] m_data;
  logic [TAG_W-1:0]  m_tag;
  logic [1:0]        p_cmd;
  logic [XLEN-1:0]   p_addr;
  logic [DATA_W-1:0] p_data;
  logic [TAG_W-1:0]  i_resp;
  logic [TAG_W-1:0]  d_resp;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic [TAG_W-1:0]  i_tag;
  logic [TAG_W-1:0]  d_tag;
  logic              err;

  int vectors;
  int miscompares;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .Icache2ctrl_command  (i_cmd),
    .Icache2ctrl_addr     (i_addr),
    .Dcache2ctrl_command  (d_cmd),
    .Dcache2ctrl_addr     (d_addr),
    .Dcache2ctrl_data     (d_data),
    .mem2proc_response    (m_resp),
    .mem2proc_data        (m_data),
    .mem2proc_tag         (m_tag),
    .proc2mem_command     (p_cmd),
    .proc2mem_addr        (p_addr),
    .proc2Dmem_data       (p_data),
    .ctrl2Icache_response (i_resp),
    .ctrl2Dcache_response (d_resp),
    .ctrl2Icache_data     (i_rdata),
    .ctrl2Dcache_data     (d_rdata),
    .ctrl2Icache_tag      (i_tag),
    .ctrl2Dcache_tag      (d_tag),
    .err_orphan_tag       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge, leaving settle time before checks.
  task automatic drive(input logic [1:0] ic, input logic [XLEN-1:0] ia,
                       input logic [1:0] dc, input logic [XLEN-1:0] da,
                       input logic [DATA_W-1:0] dd, input logic [TAG_W-1:0] rsp,
                       input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] md);
    @(negedge clock);
    i_cmd  = ic;
    i_addr = ia;
    d_cmd  = dc;
    d_addr = da;
    d_data = dd;
    m_resp = rsp;
    m_tag  = tg;
    m_data = md;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit icache_win;
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    i_cmd  = BUS_NONE;
    i_addr = '0;
    d_cmd  = BUS_NONE;
    d_addr = '0;
    d_data = '0;
    m_resp = '0;
    m_tag  = '0;
    m_data = '0;
    #12;
    chk("rst_cmd", 64'(p_cmd), 64'(BUS_NONE));
    chk("rst_addr", 64'(p_addr), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_itag", 64'(i_tag), 64'h0);
    @(negedge clock);
    reset = 1'b0;

    // Both load, Dcache wins tag 3; return goes to Dcache only.
    drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd0, 64'h0);
    chk("t1_cmd", 64'(p_cmd), 64'(BUS_LOAD));
    chk("t1_addr", 64'(p_addr), 64'h100);
    chk("t1_dresp", 64'(d_resp), 64'd3);
    chk("t1_iresp", 64'(i_resp), 64'd0);
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd3, 64'h1111_2222);
    chk("t1_dtag", 64'(d_tag), 64'd3);
    chk("t1_ddata", d_rdata, 64'h1111_2222);
    chk("t1_itag", 64'(i_tag), 64'd0);
    chk("t1_idata", i_rdata, 64'h0);

    // Icache load alone on tag 5, return DEADBEEF to Icache only.
    drive(BUS_LOAD, 32'h300, BUS_NONE, 32'h0, 64'h0, 4'd5, 4'd0, 64'h0);
    chk("t2_cmd", 64'(p_cmd), 64'(BUS_LOAD));
    chk("t2_addr", 64'(p_addr), 64'h300);
    chk("t2_iresp", 64'(i_resp), 64'd5);
    chk("t2_dresp", 64'(d_resp), 64'd0);
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd5, 64'hDEAD_BEEF);
    chk("t2_idata", i_rdata, 64'hDEAD_BEEF);
    chk("t2_itag", 64'(i_tag), 64'd5);
    chk("t2_ddata", d_rdata, 64'h0);

    // Tag 7 returned to Icache while reallocated to Dcache in the same cycle.
    drive(BUS_LOAD, 32'h400, BUS_NONE, 32'h0, 64'h0, 4'd7, 4'd0, 64'h0);
    chk("t5_iresp", 64'(i_resp), 64'd7);
    drive(BUS_NONE, 32'h0, BUS_LOAD, 32'h500, 64'h0, 4'd7, 4'd7, 64'hAAAA);
    chk("t5_dresp", 64'(d_resp), 64'd7);
    chk("t5_idata_old", i_rdata, 64'hAAAA);
    chk("t5_itag_old", 64'(i_tag), 64'd7);
    chk("t5_dtag_old", 64'(d_tag), 64'd0);
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd7, 64'hBBBB);
    chk("t5_ddata_new", d_rdata, 64'hBBBB);
    chk("t5_dtag_new", 64'(d_tag), 64'd7);
    chk("t5_idata_new", i_rdata, 64'h0);
    after_edge();
    chk("t5_err", 64'(err), 64'h0);

    // Both request continuously with every command accepted.
    for (int i = 0; i < 10; i++) begin
      drive(BUS_LOAD, 32'h600, BUS_STORE, 32'h700, 64'h5555, 4'(i + 1), 4'd0, 64'h0);
      icache_win = GUARD && ((i % 5) == 4);
      chk($sformatf("starve_cmd%0d", i), 64'(p_cmd), icache_win ? 64'(BUS_LOAD) : 64'(BUS_STORE));
      chk($sformatf("starve_addr%0d", i), 64'(p_addr), icache_win ? 64'h600 : 64'h700);
      chk($sformatf("starve_iresp%0d", i), 64'(i_resp), icache_win ? 64'(i + 1) : 64'h0);
      chk($sformatf("starve_dresp%0d", i), 64'(d_resp), icache_win ? 64'h0 : 64'(i + 1));
      chk($sformatf("starve_pdata%0d", i), p_data, icache_win ? 64'h0 : 64'h5555);
    end

    // A forced Icache grant that memory rejects keeps the grant next cycle.
    for (int i = 0; i < 6; i++) begin
      drive(BUS_LOAD, 32'h800, BUS_STORE, 32'h900, 64'h7777,
            (i == 4) ? 4'd0 : 4'd11, 4'd0, 64'h0);
      icache_win = GUARD && (i >= 4);
      chk($sformatf("force_cmd%0d", i), 64'(p_cmd), icache_win ? 64'(BUS_LOAD) : 64'(BUS_STORE));
      chk($sformatf("force_iresp%0d", i), 64'(i_resp),
          (icache_win && i == 5) ? 64'd11 : 64'h0);
      chk($sformatf("force_dresp%0d", i), 64'(d_resp),
          (icache_win || i == 4) ? 64'h0 : 64'd11);
    end
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    after_edge();
    chk("pre_orphan_err", 64'(err), 64'h0);

    // Return on tag 9 with no owner is dropped and flagged.
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd9, 64'hCCCC);
    chk("orph_itag", 64'(i_tag), 64'd0);
    chk("orph_dtag", 64'(d_tag), 64'd0);
    chk("orph_idata", i_rdata, 64'h0);
    chk("orph_ddata", d_rdata, 64'h0);
    after_edge();
    chk("orph_err", 64'(err), 64'h1);
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    after_edge();
    chk("orph_sticky", 64'(err), 64'h1);

    // Reset mid-flight: tag 2 forgotten, flag cleared asynchronously.
    drive(BUS_NONE, 32'h0, BUS_LOAD, 32'hA00, 64'h0, 4'd2, 4'd0, 64'h0);
    chk("rmf_dresp", 64'(d_resp), 64'd2);
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    reset = 1'b1;
    #1;
    chk("rmf_err_async", 64'(err), 64'h0);
    chk("rmf_cmd", 64'(p_cmd), 64'(BUS_NONE));
    @(negedge clock);
    reset = 1'b0;
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd2, 64'hEEEE);
    chk("rmf_dtag", 64'(d_tag), 64'd0);
    chk("rmf_itag", 64'(i_tag), 64'd0);
    chk("rmf_ddata", d_rdata, 64'h0);
    after_edge();
    chk("rmf_err", 64'(err), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
